// File: rtl/rom_dl_sequencer.sv
// Filters the ioctl download into the core's dn_* port, checks the image length and sequences core reset.
// States: IDLE wait | LOAD capture bytes | CHECK verify length | HOLD stretch reset | RUN core released
module rom_dl_sequencer #(
  parameter logic [24:0] EXPECT_LEN = 25'h00C000,
  parameter int          POST_RST   = 1024
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [15:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  output logic        core_reset,
  output logic        rom_ready,
  output logic        dl_error
);

  localparam int HW = (POST_RST > 1) ? $clog2(POST_RST) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_HOLD,
    S_RUN
  } state_t;

  state_t        state;
  logic [24:0]   cnt;
  logic          ovf;
  logic [HW-1:0] hold_cnt;

  logic wr_hit;
  logic in_range;
  logic go_load;

  // A write in LOAD is taken even when ioctl_download drops in the same cycle.
  assign wr_hit   = (state == S_LOAD) && ioctl_wr;
  assign in_range = ioctl_addr < EXPECT_LEN;
  assign go_load  = ioctl_download &&
                    ((state == S_IDLE) || (state == S_HOLD) || (state == S_RUN));

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      core_reset <= 1'b1;
      rom_ready  <= 1'b0;
      dl_error   <= 1'b0;
      dn_wr      <= 1'b0;
      dn_addr    <= '0;
      dn_data    <= '0;
      cnt        <= '0;
      ovf        <= 1'b0;
      hold_cnt   <= '0;
    end else begin
      dn_wr <= 1'b0;

      if (wr_hit) begin
        if (cnt != '1) cnt <= cnt + 25'd1;
        if (in_range) begin
          dn_wr   <= 1'b1;
          dn_addr <= ioctl_addr[15:0];
          dn_data <= ioctl_dout;
        end else begin
          ovf <= 1'b1;
        end
      end

      case (state)
        S_LOAD: begin
          if (!ioctl_download) state <= S_CHECK;
        end
        S_CHECK: begin
          if (ovf || (cnt != EXPECT_LEN)) begin
            dl_error <= 1'b1;
            state    <= S_IDLE;
          end else begin
            hold_cnt <= HW'(POST_RST - 1);
            state    <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (hold_cnt == '0) begin
            state      <= S_RUN;
            core_reset <= 1'b0;
            rom_ready  <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end
        S_IDLE, S_RUN: ;
        default: begin
          state      <= S_IDLE;
          core_reset <= 1'b1;
          rom_ready  <= 1'b0;
        end
      endcase

      // A new download wins over everything else, including an expiring HOLD.
      if (go_load) begin
        state      <= S_LOAD;
        cnt        <= '0;
        ovf        <= 1'b0;
        dl_error   <= 1'b0;
        core_reset <= 1'b1;
        rom_ready  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rom_dl_sequencer.sv
// Randomized scoreboard bench for rom_dl_sequencer, using a short image so many loads fit in the run.
module tb_rom_dl_sequencer;

  localparam logic [24:0] LEN = 25'd48;
  localparam int          P   = 20;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic        core_reset;
  logic        rom_ready;
  logic        dl_error;

  rom_dl_sequencer #(.EXPECT_LEN(LEN), .POST_RST(P)) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout),
    .dn_addr(dn_addr),
    .dn_data(dn_data),
    .dn_wr(dn_wr),
    .core_reset(core_reset),
    .rom_ready(rom_ready),
    .dl_error(dl_error)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: every dn_wr must match the oldest accepted byte, exactly one cycle after its strobe.
  always @(negedge clk_sys) begin
    if (!reset && dn_wr) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL dn_wr_unexpected: got write to %0h expected none", dn_addr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("dn_addr", 32'(dn_addr), 32'(e.addr));
        check("dn_data", 32'(dn_data), 32'(e.data));
        check("dn_latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [24:0] oob_addr();
    logic [24:0] a;
    case ($urandom_range(0, 3))
      0:       a = LEN;
      1:       a = LEN + 25'($urandom_range(1, 15));
      2:       a = 25'h10000 | 25'($urandom_range(0, int'(LEN) - 1));
      default: a = 25'h1FFFFFF;
    endcase
    return a;
  endfunction

  // Outcome after the download window closes; offset accounts for a last write that already saw download=0.
  task automatic finish_check(input bit err, input int offset, input int abort_after);
    int hi = 0;
    int lows = 0;
    int rdy = 0;
    bit released = 0;
    if (abort_after >= 0) begin
      for (int k = 0; k < abort_after; k++) begin
        @(negedge clk_sys);
        if (!core_reset) lows++;
        if (rom_ready) rdy++;
      end
      check("hold_core_reset_low_cycles", 32'(lows), 32'd0);
      check("hold_rom_ready_cycles", 32'(rdy), 32'd0);
    end else if (!err) begin
      for (int k = 0; k < P + 20 && !released; k++) begin
        @(negedge clk_sys);
        if (core_reset) hi++;
        else released = 1;
      end
      check("release_delay", 32'(hi), 32'(P + 2 - offset));
      check("rom_ready_after_good", 32'(rom_ready), 32'd1);
      check("dl_error_after_good", 32'(dl_error), 32'd0);
    end else begin
      for (int k = 0; k < P + 10; k++) begin
        @(negedge clk_sys);
        if (!core_reset) lows++;
        if (rom_ready) rdy++;
      end
      check("bad_core_reset_low_cycles", 32'(lows), 32'd0);
      check("bad_rom_ready_cycles", 32'(rdy), 32'd0);
      check("dl_error_after_bad", 32'(dl_error), 32'd1);
    end
    step();
  endtask

  // One download session: n_in sequential in-range bytes with n_oob out-of-range writes mixed in.
  task automatic do_load(input int n_in, input int n_oob, input bit last_on_fall, input int abort_after);
    logic [24:0] q[$];
    bit any_oob = 0;
    bit err;
    for (int i = 0; i < n_in; i++) q.push_back(25'(i));
    for (int j = 0; j < n_oob; j++) q.insert($urandom_range(0, q.size()), oob_addr());
    foreach (q[i]) if (q[i] >= LEN) any_oob = 1;
    err = any_oob || (q.size() != int'(LEN));

    ioctl_download = 1'b1;
    step();
    @(negedge clk_sys);
    check("load_entry_core_reset", 32'(core_reset), 32'd1);
    check("load_entry_rom_ready", 32'(rom_ready), 32'd0);
    check("load_entry_dl_error", 32'(dl_error), 32'd0);
    step();

    for (int i = 0; i < q.size(); i++) begin
      bit last;
      exp_t e;
      last = (i == q.size() - 1);
      ioctl_wr   = 1'b1;
      ioctl_addr = q[i];
      ioctl_dout = 8'($urandom);
      if (last && last_on_fall) ioctl_download = 1'b0;
      if (q[i] < LEN) begin
        e.addr = q[i][15:0];
        e.data = ioctl_dout;
        e.cyc  = cyc + 1;
        sb.push_back(e);
      end
      step();
      ioctl_wr = 1'b0;
      if (!(last && last_on_fall)) repeat ($urandom_range(0, 2)) step();
    end
    ioctl_download = 1'b0;
    finish_check(err, last_on_fall ? 1 : 0, err ? -1 : abort_after);
  endtask

  task automatic reset_mid_load(input int k);
    exp_t e;
    ioctl_download = 1'b1;
    step();
    step();
    for (int i = 0; i < k; i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(i);
      ioctl_dout = 8'($urandom);
      e.addr = 16'(i);
      e.data = ioctl_dout;
      e.cyc  = cyc + 1;
      sb.push_back(e);
      step();
      ioctl_wr = 1'b0;
    end
    reset = 1'b1;
    #1;
    check("midrst_core_reset", 32'(core_reset), 32'd1);
    check("midrst_rom_ready", 32'(rom_ready), 32'd0);
    check("midrst_dl_error", 32'(dl_error), 32'd0);
    check("midrst_dn_wr", 32'(dn_wr), 32'd0);
    check("midrst_dn_addr", 32'(dn_addr), 32'd0);
    check("midrst_dn_data", 32'(dn_data), 32'd0);
    sb.delete();
    ioctl_download = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    repeat (3) step();
    check("rst_core_reset", 32'(core_reset), 32'd1);
    check("rst_rom_ready", 32'(rom_ready), 32'd0);
    check("rst_dl_error", 32'(dl_error), 32'd0);
    check("rst_dn_wr", 32'(dn_wr), 32'd0);
    check("rst_dn_addr", 32'(dn_addr), 32'd0);
    check("rst_dn_data", 32'(dn_data), 32'd0);
    reset = 1'b0;
    repeat (3) step();
    check("idle_core_reset", 32'(core_reset), 32'd1);

    do_load(int'(LEN), 0, 0, -1);       // good image
    do_load(int'(LEN), 0, 0, -1);       // re-download from RUN
    do_load(int'(LEN), 0, 0, 8);        // abort in HOLD
    do_load(int'(LEN), 0, 0, -1);       // re-download from HOLD releases
    do_load(int'(LEN) - 1, 0, 0, -1);   // short
    do_load(int'(LEN), 0, 0, -1);
    do_load(int'(LEN), 1, 0, -1);       // long, extra out-of-range byte
    do_load(int'(LEN) - 1, 1, 0, -1);   // right count but out-of-range write
    do_load(int'(LEN), 0, 1, -1);       // last byte as download falls
    reset_mid_load(int'(LEN) / 3);
    do_load(int'(LEN), 0, 0, -1);

    for (int r = 0; r < 8; r++) begin
      int n_in;
      n_in = int'(LEN) - int'($urandom_range(0, 2));
      do_load(n_in, int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end

    repeat (3) step();
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
